// File: rtl/stopwatch_ctrl_pkg.sv
// Shared stopwatch definitions: default widths, counter ceiling and the
// controller state encoding.
package stopwatch_ctrl_pkg;

  localparam int CNT_W     = 47;
  localparam int LAP_DEPTH = 4;

  // The time counter wraps on its own at this value.
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_PAUSE = 2'd3
  } sw_state_t;

endpackage

// File: rtl/stopwatch_ctrl_edge_detect.sv
// Rising-edge detector for a debounced button level; one pulse per press.
// The detector stays disarmed until the level has been seen low after reset.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic sample_q, sample_d;
  logic armed_q, armed_d;

  always_comb begin
    sample_d = level_i;
    // A button held through reset release must be let go before it counts.
    armed_d  = armed_q | ~level_i;
    pulse_o  = level_i & ~sample_q & armed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sample_q <= sample_d;
      armed_q  <= armed_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear buttons drive a four-state
// FSM, a frozen-display hold register and a circular lap file.
module stopwatch_ctrl #(
  parameter int CNT_W     = stopwatch_ctrl_pkg::CNT_W,
  parameter int LAP_DEPTH = stopwatch_ctrl_pkg::LAP_DEPTH,
  localparam int AW       = $clog2(LAP_DEPTH)
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             startIn,
  input  logic             lapIn,
  input  logic [AW-1:0]    lapSelIn,
  input  logic [CNT_W-1:0] cntValIn,
  output logic             cntEnOut,
  output logic             cntClrOut,
  output logic [CNT_W-1:0] dispValOut,
  output logic [CNT_W-1:0] lapValOut,
  output logic [AW:0]      lapCntOut,
  output logic             holdOut
);

  import stopwatch_ctrl_pkg::*;

  localparam logic [AW:0]   LAP_FULL = LAP_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  function automatic logic [AW:0] lap_cnt_sat_inc(input logic [AW:0] c);
    return (c == LAP_FULL) ? c : c + CNT_ONE;
  endfunction

  logic start_p, lap_p;

  sw_state_t        state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic [CNT_W-1:0] lapv_q, lapv_d;
  logic [CNT_W-1:0] lap_q [LAP_DEPTH];
  logic [CNT_W-1:0] lap_d [LAP_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW:0]      lcnt_q, lcnt_d;
  logic             clr_q, clr_d;

  edge_detect u_start_edge (.clk(clkIn), .rst_n(rstIn), .level_i(startIn), .pulse_o(start_p));
  edge_detect u_lap_edge   (.clk(clkIn), .rst_n(rstIn), .level_i(lapIn),   .pulse_o(lap_p));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    lap_d   = lap_q;
    wptr_d  = wptr_q;
    lcnt_d  = lcnt_q;
    clr_d   = 1'b0;
    // Start wins over a coincident lap press; the lap press is dropped.
    if (start_p) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_HOLD:  state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else if (lap_p) begin
      case (state_q)
        ST_RUN: begin
          hold_d        = cntValIn;
          lap_d[wptr_q] = cntValIn;
          wptr_d        = wptr_q + PTR_ONE;
          lcnt_d        = lap_cnt_sat_inc(lcnt_q);
          state_d       = ST_HOLD;
        end
        ST_HOLD:  state_d = ST_RUN;
        ST_PAUSE: begin
          clr_d   = 1'b1;
          wptr_d  = '0;
          lcnt_d  = '0;
          state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
    disp_d = (state_q == ST_HOLD) ? hold_q : cntValIn;
    lapv_d = ({1'b0, lapSelIn} < lcnt_q) ? lap_q[lapSelIn] : '0;
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      disp_q  <= '0;
      lapv_q  <= '0;
      wptr_q  <= '0;
      lcnt_q  <= '0;
      clr_q   <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      lapv_q  <= lapv_d;
      wptr_q  <= wptr_d;
      lcnt_q  <= lcnt_d;
      clr_q   <= clr_d;
      for (int i = 0; i < LAP_DEPTH; i++) lap_q[i] <= lap_d[i];
    end
  end

  assign cntEnOut   = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign holdOut    = (state_q == ST_HOLD);
  assign cntClrOut  = clr_q;
  assign dispValOut = disp_q;
  assign lapValOut  = lapv_q;
  assign lapCntOut  = lcnt_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with hand-computed expected values.
module tb_stopwatch_ctrl;

  localparam int CNT_W = 47;
  localparam int LAP_DEPTH = 4;
  localparam int AW = 2;

  logic             clkIn = 1'b0;
  logic             rstIn;
  logic             startIn;
  logic             lapIn;
  logic [AW-1:0]    lapSelIn;
  logic [CNT_W-1:0] cntValIn;
  logic             cntEnOut;
  logic             cntClrOut;
  logic [CNT_W-1:0] dispValOut;
  logic [CNT_W-1:0] lapValOut;
  logic [AW:0]      lapCntOut;
  logic             holdOut;

  int total = 0;
  int bad = 0;

  stopwatch_ctrl #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .lapIn(lapIn),
    .lapSelIn(lapSelIn), .cntValIn(cntValIn), .cntEnOut(cntEnOut),
    .cntClrOut(cntClrOut), .dispValOut(dispValOut), .lapValOut(lapValOut),
    .lapCntOut(lapCntOut), .holdOut(holdOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic press_start();
    startIn = 1'b1; tick();
    startIn = 1'b0; tick();
  endtask

  task automatic press_lap();
    lapIn = 1'b1; tick();
    lapIn = 1'b0; tick();
  endtask

  task automatic read_lap(input logic [AW-1:0] sel, input logic [63:0] exp, input string tag);
    lapSelIn = sel;
    tick();
    chk(tag, lapValOut, exp);
  endtask

  initial begin
    rstIn = 1'b0; startIn = 1'b0; lapIn = 1'b0; lapSelIn = '0; cntValIn = '0;
    tick(); tick();
    chk("rst_en", cntEnOut, 0);
    chk("rst_clr", cntClrOut, 0);
    chk("rst_disp", dispValOut, 0);
    chk("rst_lapval", lapValOut, 0);
    chk("rst_lapcnt", lapCntOut, 0);
    chk("rst_hold", holdOut, 0);
    rstIn = 1'b1;
    tick(); tick();

    // IDLE -> RUN -> PAUSE
    press_start();
    chk("run_en", cntEnOut, 1);
    chk("run_hold", holdOut, 0);
    press_start();
    chk("pause_en", cntEnOut, 0);
    press_start();
    chk("rerun_en", cntEnOut, 1);

    // Lap capture and frozen display
    cntValIn = 1000;
    tick();
    chk("run_disp_live", dispValOut, 1000);
    press_lap();
    cntValIn = 1005;
    tick();
    chk("hold_flag", holdOut, 1);
    chk("hold_disp", dispValOut, 1000);
    chk("hold_lapcnt", lapCntOut, 1);
    chk("hold_en", cntEnOut, 1);
    read_lap(2'd0, 1000, "lap0_1000");
    read_lap(2'd1, 0, "lap1_empty");
    cntValIn = 1010;
    press_lap();
    chk("unhold_flag", holdOut, 0);
    chk("unhold_disp", dispValOut, 1010);
    chk("unhold_lapcnt", lapCntOut, 1);

    // PAUSE then lap clears
    press_start();
    chk("pause2_en", cntEnOut, 0);
    lapIn = 1'b1; tick();
    chk("clr_pulse", cntClrOut, 1);
    chk("clr_lapcnt", lapCntOut, 0);
    lapIn = 1'b0; tick();
    chk("clr_single", cntClrOut, 0);
    chk("idle_en", cntEnOut, 0);
    read_lap(2'd0, 0, "lap0_after_clr");

    // Lap in IDLE is ignored
    lapIn = 1'b1; tick();
    chk("idle_lap_clr", cntClrOut, 0);
    lapIn = 1'b0; tick();
    chk("idle_lap_en", cntEnOut, 0);
    chk("idle_lap_hold", holdOut, 0);

    // Five captures into a four-entry circular file
    press_start();
    for (int v = 1; v <= 5; v++) begin
      cntValIn = 47'(v * 10);
      press_lap();
      press_lap();
    end
    chk("wrap_lapcnt", lapCntOut, 4);
    read_lap(2'd0, 50, "wrap_lap0");
    read_lap(2'd1, 20, "wrap_lap1");
    read_lap(2'd2, 30, "wrap_lap2");
    read_lap(2'd3, 40, "wrap_lap3");

    // Simultaneous start and lap in RUN: pause, no capture
    cntValIn = 77;
    startIn = 1'b1; lapIn = 1'b1; tick();
    startIn = 1'b0; lapIn = 1'b0; tick();
    chk("sim_en", cntEnOut, 0);
    chk("sim_hold", holdOut, 0);
    chk("sim_lapcnt", lapCntOut, 4);
    read_lap(2'd1, 20, "sim_lap1");
    read_lap(2'd0, 50, "sim_lap0");

    // Reset mid-HOLD with start held
    press_start();
    cntValIn = 500;
    press_lap();
    tick();
    chk("pre_rst_hold", holdOut, 1);
    chk("pre_rst_disp", dispValOut, 500);
    startIn = 1'b1; rstIn = 1'b0;
    #2;
    chk("async_en", cntEnOut, 0);
    chk("async_hold", holdOut, 0);
    chk("async_disp", dispValOut, 0);
    chk("async_lapval", lapValOut, 0);
    chk("async_lapcnt", lapCntOut, 0);
    chk("async_clr", cntClrOut, 0);
    tick();
    rstIn = 1'b1;
    tick(); tick(); tick();
    chk("held_no_start", cntEnOut, 0);
    chk("held_no_clr", cntClrOut, 0);
    startIn = 1'b0; tick();
    startIn = 1'b1; tick();
    chk("repress_en", cntEnOut, 1);
    startIn = 1'b0; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CNT_W, default 47: width of the time count in 10 ns ticks.
REQ-002 Parameter LAP_DEPTH, default 4: number of stored lap entries (power of 2).
REQ-003 clkIn  input  1  system clock, 100 MHz, all logic on its rising edge.
REQ-004 rstIn  input  1  reset, asynchronous, active-low.
REQ-005 startIn  input  1  debounced start/stop button level.
REQ-006 lapIn  input  1  debounced lap/clear button level.
REQ-007 lapSelIn  input  log2(LAP_DEPTH)  lap entry index for readback.
REQ-008 cntValIn  input  CNT_W  live value from the time counter.
REQ-009 cntEnOut  output  1  time counter enable.
REQ-010 cntClrOut  output  1  one-cycle synchronous clear pulse to the time counter.
REQ-011 dispValOut  output  CNT_W  value routed to the digit-split/display path.
REQ-012 lapValOut  output  CNT_W  stored lap entry selected by lapSelIn.
REQ-013 lapCntOut  output  log2(LAP_DEPTH)+1  number of valid lap entries, 0..LAP_DEPTH.
REQ-014 holdOut  output  1  high while the display is frozen on a lap value.

Function
REQ-015 Rising edges of startIn and lapIn SHALL each be detected as startIn=1 with previous-cycle sample 0, giving one pulse per press.
REQ-016 The FSM SHALL have four states: IDLE (stopped, cleared), RUN, HOLD (counting, display frozen), PAUSE.
REQ-017 A start pulse SHALL move IDLE->RUN, RUN->PAUSE, HOLD->PAUSE and PAUSE->RUN at the same clock edge that detects it.
REQ-018 A lap pulse in RUN SHALL capture cntValIn into the hold register and into the lap file, then move to HOLD.
REQ-019 A lap pulse in HOLD SHALL move to RUN with no capture.
REQ-020 A lap pulse in PAUSE SHALL assert cntClrOut for exactly one cycle, zero lapCntOut and the write pointer, and move to IDLE.
REQ-021 A lap pulse in IDLE SHALL be ignored.
REQ-022 When start and lap pulses occur in the same cycle, the start pulse SHALL be processed and the lap pulse discarded.
REQ-023 cntEnOut SHALL be 1 exactly in RUN and HOLD, decoded from the registered state.
REQ-024 dispValOut SHALL be registered with one cycle of latency: the hold register in HOLD, otherwise cntValIn.
REQ-025 The lap file SHALL be written circularly: when full, the oldest entry is overwritten and lapCntOut saturates at LAP_DEPTH.
REQ-026 lapValOut SHALL be registered with one cycle of latency from lapSelIn; entries at or above lapCntOut SHALL read as 0.
REQ-027 holdOut SHALL be 1 exactly in HOLD.
REQ-028 Counter wrap at MAX_CNT SHALL need no controller action; captured values are stored unmodified.

Reset
REQ-029 Assertion of rstIn SHALL immediately force state IDLE, cntEnOut=0, cntClrOut=0, dispValOut=0, lapValOut=0, lapCntOut=0, holdOut=0, write pointer 0, all lap entries 0 and both edge samples 0.
REQ-030 Reset asserted mid-RUN or mid-HOLD SHALL discard all state, with no clear pulse emitted.
REQ-031 A button held through reset release SHALL NOT produce a pulse until it is released and pressed again.

Structure
REQ-032 The state encoding, CNT_W, LAP_DEPTH and MAX_CNT SHALL live in the shared stopwatch definitions package.
REQ-033 Rising-edge detection SHALL be a sub-module edge_detect, instantiated twice.

Verification
REQ-034 Start pulse from IDLE -> cntEnOut=1 at the next cycle; a second start pulse -> PAUSE, cntEnOut=0.
REQ-035 RUN with cntValIn=1000, lap pulse -> holdOut=1, dispValOut holds 1000 while cntValIn advances, lapCntOut=1; lap again -> dispValOut tracks live.
REQ-036 Five lap captures at values 10,20,30,40,50 -> lapCntOut=4, lapSelIn=0 reads 50, 1..3 read 20,30,40.
REQ-037 PAUSE, lap pulse -> single-cycle cntClrOut, lapCntOut=0, state IDLE; lap pulse in IDLE -> no cntClrOut.
REQ-038 Simultaneous start and lap pulses in RUN -> PAUSE, no capture, lapCntOut unchanged.
REQ-039 rstIn low mid-HOLD with startIn held -> all outputs 0; after release, no transition until startIn falls and rises again.
